// File: rtl/mrv1_pkg.sv
// Shared types for the mrv1 execution-stage writeback path: functional-unit
// indices, default field widths and the buffered completion record.
package mrv1_pkg;

  localparam int NUM_FU     = 6;
  localparam int DATA_WIDTH = 32;
  localparam int ITAG_WIDTH = 3;
  localparam int TID_WIDTH  = 3;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_LSU = 3'd1,
    FU_MUL = 3'd2,
    FU_DIV = 3'd3,
    FU_BR  = 3'd4,
    FU_CTL = 3'd5
  } fu_idx_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ITAG_WIDTH-1:0] itag;
    logic [TID_WIDTH-1:0]  tid;
  } wb_entry_t;

endpackage

// File: rtl/mrv1_wb_fifo.sv
// Synchronous FIFO of writeback entries for one functional unit. A push into
// a full FIFO is accepted only when the head is popped in the same cycle;
// otherwise it is dropped and the caller flags the overflow.
module mrv1_wb_fifo
  import mrv1_pkg::*;
#(
  parameter int DEPTH_P = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t wdata,
  output wb_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH_P);

  // Extra MSB on each pointer distinguishes full from empty when the
  // address bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH_P];
  logic        wr_en;
  logic        rd_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO regardless of pending push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter: buffers each FU's completions in its own FIFO and grants
// one head per cycle to the register-file writeback port, round-robin across
// FUs. A grant that meets backpressure is locked until it is accepted. Per-FU
// outstanding counters produce the issue credits.
module mrv1_wb_arb
  import mrv1_pkg::*;
#(
  parameter int NUM_FU_P     = NUM_FU,
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter int ITAG_WIDTH_P = ITAG_WIDTH,
  parameter int TID_WIDTH_P  = TID_WIDTH,
  parameter int FIFO_DEPTH_P = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_FU_P-1:0]              fu_issue_i,
  output logic [NUM_FU_P-1:0]              fu_credit_o,
  input  logic [NUM_FU_P-1:0]              fu_done_i,
  input  logic [NUM_FU_P*DATA_WIDTH_P-1:0] fu_data_i,
  input  logic [NUM_FU_P*ITAG_WIDTH_P-1:0] fu_itag_i,
  input  logic [NUM_FU_P*TID_WIDTH_P-1:0]  fu_tid_i,
  output logic                             wb_vld_o,
  input  logic                             wb_rdy_i,
  output logic [DATA_WIDTH_P-1:0]          wb_data_o,
  output logic [ITAG_WIDTH_P-1:0]          wb_itag_o,
  output logic [TID_WIDTH_P-1:0]           wb_tid_o,
  output logic [$clog2(NUM_FU_P)-1:0]      wb_fu_o,
  output logic                             ovf_err_o
);

  localparam int FU_W = $clog2(NUM_FU_P);
  localparam int CW   = $clog2(FIFO_DEPTH_P) + 1;

  wb_entry_t           head [NUM_FU_P];
  logic [NUM_FU_P-1:0] full;
  logic [NUM_FU_P-1:0] empty;
  logic [NUM_FU_P-1:0] pop;

  logic [FU_W-1:0] rr_ptr;
  logic            lock_vld;
  logic [FU_W-1:0] lock_fu;
  logic [FU_W-1:0] arb_fu;
  logic            arb_found;
  logic [FU_W-1:0] grant_fu;
  logic            hs;
  int              idx;

  logic [CW-1:0] outstanding [NUM_FU_P];

  // One completion FIFO per functional unit.
  for (genvar g = 0; g < NUM_FU_P; g++) begin : g_fu
    wb_entry_t wdata;
    assign wdata = '{data: fu_data_i[g*DATA_WIDTH_P +: DATA_WIDTH_P],
                     itag: fu_itag_i[g*ITAG_WIDTH_P +: ITAG_WIDTH_P],
                     tid:  fu_tid_i[g*TID_WIDTH_P +: TID_WIDTH_P]};

    mrv1_wb_fifo #(.DEPTH_P(FIFO_DEPTH_P)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (fu_done_i[g]),
      .pop   (pop[g]),
      .wdata (wdata),
      .rdata (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Round-robin search: first non-empty FIFO at or after the pointer.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; every output gets a default first so no latch is inferred.
  always_comb begin
    arb_fu    = '0;
    arb_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_FU_P; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_FU_P) idx = idx - NUM_FU_P;
      if (!arb_found && !empty[idx]) begin
        arb_found = 1'b1;
        arb_fu    = FU_W'(idx);
      end
    end
  end

  // A locked grant stays put under backpressure; its FIFO cannot drain
  // without a handshake, so it is still non-empty.
  assign grant_fu = lock_vld ? lock_fu : arb_fu;
  assign wb_vld_o = lock_vld || arb_found;
  assign hs       = wb_vld_o && wb_rdy_i;

  // Writeback output mux and per-FU pop; outputs read zero when idle.
  always_comb begin
    wb_data_o = '0;
    wb_itag_o = '0;
    wb_tid_o  = '0;
    wb_fu_o   = '0;
    pop       = '0;
    for (int i = 0; i < NUM_FU_P; i++) begin
      if (wb_vld_o && grant_fu == FU_W'(i)) begin
        wb_data_o = head[i].data;
        wb_itag_o = head[i].itag;
        wb_tid_o  = head[i].tid;
        wb_fu_o   = FU_W'(i);
        pop[i]    = hs;
      end
    end
  end

  // Grant lock and round-robin pointer.
  // NOTE: clocked state uses non-blocking '<=' so all registers update
  // together from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_vld <= 1'b0;
      lock_fu  <= '0;
      rr_ptr   <= '0;
    end else if (hs) begin
      lock_vld <= 1'b0;
      rr_ptr   <= (grant_fu == FU_W'(NUM_FU_P-1)) ? '0 : grant_fu + FU_W'(1);
    end else if (wb_vld_o) begin
      lock_vld <= 1'b1;
      lock_fu  <= grant_fu;
    end
  end

  // Outstanding-request counters: +1 on issue, -1 on writeback, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_FU_P; n++) outstanding[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_FU_P; n++) begin
        case ({fu_issue_i[n], pop[n]})
          2'b10: if (outstanding[n] < CW'(FIFO_DEPTH_P)) outstanding[n] <= outstanding[n] + CW'(1);
          2'b01: if (outstanding[n] != '0) outstanding[n] <= outstanding[n] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Credit is available while the registered count is below the FIFO depth.
  always_comb begin
    fu_credit_o = '0;
    for (int n = 0; n < NUM_FU_P; n++) fu_credit_o[n] = (outstanding[n] < CW'(FIFO_DEPTH_P));
  end

  // Sticky overflow: a completion arrived at a full FIFO with no pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_err_o <= 1'b0;
    else if (|(fu_done_i & full & ~pop)) ovf_err_o <= 1'b1;
  end

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Self-checking bench for mrv1_wb_arb: directed scenarios push the expected
// writebacks (in grant order) into a scoreboard; a negedge monitor pops and
// compares on every handshake.
module tb_mrv1_wb_arb;
  import mrv1_pkg::*;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int TW = 3;

  typedef struct {
    int             fu;
    logic [DW-1:0]  data;
    logic [IW-1:0]  itag;
    logic [TW-1:0]  tid;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    fu_issue;
  logic [N-1:0]    fu_credit;
  logic [N-1:0]    fu_done;
  logic [N*DW-1:0] fu_data;
  logic [N*IW-1:0] fu_itag;
  logic [N*TW-1:0] fu_tid;
  logic            wb_vld;
  logic            wb_rdy;
  logic [DW-1:0]   wb_data;
  logic [IW-1:0]   wb_itag;
  logic [TW-1:0]   wb_tid;
  logic [2:0]      wb_fu;
  logic            ovf_err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];

  mrv1_wb_arb dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .fu_issue_i  (fu_issue),
    .fu_credit_o (fu_credit),
    .fu_done_i   (fu_done),
    .fu_data_i   (fu_data),
    .fu_itag_i   (fu_itag),
    .fu_tid_i    (fu_tid),
    .wb_vld_o    (wb_vld),
    .wb_rdy_i    (wb_rdy),
    .wb_data_o   (wb_data),
    .wb_itag_o   (wb_itag),
    .wb_tid_o    (wb_tid),
    .wb_fu_o     (wb_fu),
    .ovf_err_o   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input int fu, input logic [DW-1:0] d, input logic [IW-1:0] it,
                          input logic [TW-1:0] td);
    fu_done[fu]            = 1'b1;
    fu_data[fu*DW +: DW]   = d;
    fu_itag[fu*IW +: IW]   = it;
    fu_tid[fu*TW +: TW]    = td;
  endtask

  task automatic push_exp(input int fu, input logic [DW-1:0] d, input logic [IW-1:0] it,
                          input logic [TW-1:0] td);
    exp_t e;
    e.fu = fu; e.data = d; e.itag = it; e.tid = td;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    fu_done  = '0;
    fu_issue = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 50; c++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && wb_vld && wb_rdy) begin
      check("wb_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wb_fu",   64'(wb_fu),   64'(e.fu));
        check("wb_data", 64'(wb_data), 64'(e.data));
        check("wb_itag", 64'(wb_itag), 64'(e.itag));
        check("wb_tid",  64'(wb_tid),  64'(e.tid));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fu_issue = '0; fu_done = '0; fu_data = '0; fu_itag = '0; fu_tid = '0;
    wb_rdy = 1'b0;

    // 1 Reset with done pulses present.
    tick();
    for (int i = 0; i < N; i++) set_done(i, 32'h1000 + i, 3'(i), 3'(i));
    repeat (2) tick();
    rst = 1'b0; fu_done = '0;
    @(negedge clk);
    check("rst_vld",    64'(wb_vld),    64'd0);
    check("rst_credit", 64'(fu_credit), 64'h3f);
    check("rst_ovf",    64'(ovf_err),   64'd0);
    check("rst_data",   64'(wb_data),   64'd0);
    tick();
    check("rst_still_idle", 64'(wb_vld), 64'd0);

    // 2 Single completion on FU2.
    wb_rdy = 1'b1;
    fu_issue[FU_MUL] = 1'b1;
    set_done(FU_MUL, 32'hDEAD, 3'd5, 3'd3);
    push_exp(FU_MUL, 32'hDEAD, 3'd5, 3'd3);
    @(negedge clk);
    check("single_no_bypass", 64'(wb_vld), 64'd0);
    tick();
    fu_issue = '0; fu_done = '0;
    @(negedge clk);
    check("single_vld",     64'(wb_vld),       64'd1);
    check("single_credit",  64'(fu_credit[2]), 64'd1);
    wait_drain("single_drain");
    check("single_credit_after", 64'(fu_credit), 64'h3f);

    // 3 Round-robin from a freshly reset pointer, then wrap.
    apply_reset();
    wb_rdy = 1'b1;
    set_done(FU_ALU, 32'hA000, 3'd0, 3'd1);
    set_done(FU_LSU, 32'hA001, 3'd1, 3'd2);
    set_done(FU_BR,  32'hA004, 3'd4, 3'd5);
    push_exp(FU_ALU, 32'hA000, 3'd0, 3'd1);
    push_exp(FU_LSU, 32'hA001, 3'd1, 3'd2);
    push_exp(FU_BR,  32'hA004, 3'd4, 3'd5);
    tick();
    fu_done = '0;
    wait_drain("rr_first_drain");
    set_done(FU_ALU, 32'hB000, 3'd2, 3'd0);
    set_done(FU_LSU, 32'hB001, 3'd3, 3'd0);
    set_done(FU_BR,  32'hB004, 3'd6, 3'd7);
    push_exp(FU_ALU, 32'hB000, 3'd2, 3'd0);
    push_exp(FU_LSU, 32'hB001, 3'd3, 3'd0);
    push_exp(FU_BR,  32'hB004, 3'd6, 3'd7);
    tick();
    fu_done = '0;
    wait_drain("rr_wrap_drain");

    // 4 Backpressure: grant to FU3 locked while FU0 fills.
    wb_rdy = 1'b0;
    set_done(FU_DIV, 32'h3333, 3'd7, 3'd6);
    tick();
    fu_done = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) set_done(FU_ALU, 32'hC000 + i, 3'(i), 3'd4);
      @(negedge clk);
      check("bp_vld",  64'(wb_vld),  64'd1);
      check("bp_fu",   64'(wb_fu),   64'd3);
      check("bp_data", 64'(wb_data), 64'h3333);
      check("bp_itag", 64'(wb_itag), 64'd7);
      tick();
      fu_done = '0;
    end
    push_exp(FU_DIV, 32'h3333, 3'd7, 3'd6);
    push_exp(FU_ALU, 32'hC000, 3'd0, 3'd4);
    push_exp(FU_ALU, 32'hC001, 3'd1, 3'd4);
    wb_rdy = 1'b1;
    wait_drain("bp_drain");

    // 5 Credits on FU1.
    fu_issue[FU_LSU] = 1'b1;
    tick();
    @(negedge clk);
    check("cred_one_issue", 64'(fu_credit[1]), 64'd1);
    tick();
    fu_issue = '0;
    @(negedge clk);
    check("cred_two_issue", 64'(fu_credit[1]), 64'd0);
    set_done(FU_LSU, 32'h1111, 3'd1, 3'd1);
    push_exp(FU_LSU, 32'h1111, 3'd1, 3'd1);
    tick();
    fu_done = '0;
    fu_issue[FU_LSU] = 1'b1;
    tick();
    fu_issue = '0;
    @(negedge clk);
    check("cred_issue_and_wb", 64'(fu_credit[1]), 64'd0);
    set_done(FU_LSU, 32'h2222, 3'd2, 3'd2);
    push_exp(FU_LSU, 32'h2222, 3'd2, 3'd2);
    tick();
    fu_done = '0;
    tick();
    @(negedge clk);
    check("cred_one_wb", 64'(fu_credit[1]), 64'd1);
    wait_drain("cred_drain");

    // 6 Overflow on FU5: third completion is dropped.
    wb_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_done(FU_CTL, 32'h5550 + i, 3'(i), 3'd5);
      tick();
    end
    fu_done = '0;
    @(negedge clk);
    check("ovf_set", 64'(ovf_err), 64'd1);
    push_exp(FU_CTL, 32'h5550, 3'd0, 3'd5);
    push_exp(FU_CTL, 32'h5551, 3'd1, 3'd5);
    wb_rdy = 1'b1;
    wait_drain("ovf_drain");
    repeat (3) tick();
    @(negedge clk);
    check("ovf_dropped", 64'(wb_vld),  64'd0);
    check("ovf_sticky",  64'(ovf_err), 64'd1);

    // Reset mid-operation discards a buffered result and clears the error.
    wb_rdy = 1'b0;
    fu_issue[FU_MUL] = 1'b1;
    set_done(FU_MUL, 32'h9999, 3'd4, 3'd4);
    tick();
    fu_done = '0; fu_issue = '0;
    apply_reset();
    @(negedge clk);
    check("midrst_vld",    64'(wb_vld),    64'd0);
    check("midrst_ovf",    64'(ovf_err),   64'd0);
    check("midrst_credit", 64'(fu_credit), 64'h3f);
    wb_rdy = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("midrst_idle", 64'(wb_vld), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
